// File: rtl/requant_pkg.sv
// Shared widths, saturation bounds, FSM states and the latched frame configuration
// for the int32 -> int8 requantise-and-pack stream.
package requant_pkg;
   localparam int unsigned LANES   = 8;
   localparam int unsigned ACC_W   = 32;
   localparam int unsigned SCALE_W = 16;
   localparam int unsigned SHIFT_W = 5;
   localparam int unsigned OUT_W   = 8;
   localparam int unsigned CNT_W   = 32;
   localparam int unsigned PROD_W  = ACC_W + SCALE_W;
   localparam int unsigned EXT_W   = PROD_W + 1;

   localparam int SAT_MAX = 127;
   localparam int SAT_MIN = -128;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic signed [SCALE_W-1:0] scale;
      logic [SHIFT_W-1:0]        shift;
      logic signed [OUT_W-1:0]   zero;
      logic [CNT_W-1:0]          total;
   } cfg_t;
endpackage

// File: rtl/requant_lane.sv
// One lane of the requantiser: S1 scale multiply, S2 round-half-up shift,
// zero-point add and int8 saturation.
module requant_lane
   import requant_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s1_load,
   input  logic                      s2_load,
   input  logic signed [ACC_W-1:0]   acc,
   input  logic signed [SCALE_W-1:0] scale,
   input  logic [SHIFT_W-1:0]        shift,
   input  logic signed [OUT_W-1:0]   zero,
   output logic [OUT_W-1:0]          q
);
   logic signed [PROD_W-1:0] prod;
   logic signed [EXT_W-1:0]  rnd;
   logic signed [EXT_W-1:0]  shifted;
   logic signed [EXT_W-1:0]  biased;
   logic [OUT_W-1:0]         sat;

   // One extra bit of headroom so rounding and zero-point add never wrap
   always_comb begin
      rnd = '0;
      if (shift != '0) rnd = EXT_W'(1) <<< (shift - SHIFT_W'(1));
      shifted = (EXT_W'(prod) + rnd) >>> shift;
      biased  = shifted + EXT_W'(zero);
      if (biased > EXT_W'(SAT_MAX))      sat = OUT_W'(SAT_MAX);
      else if (biased < EXT_W'(SAT_MIN)) sat = OUT_W'(SAT_MIN);
      else                               sat = OUT_W'(biased);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prod <= '0;
         q    <= '0;
      end else begin
         if (s1_load) prod <= acc * scale;
         if (s2_load) q <= sat;
      end
   end
endmodule

// File: rtl/requant_pack_stream.sv
// Frame-level requantise-and-pack stream: FSM, beat counter, 2-stage valid/last
// pipe with per-stage stall, and LANES requant_lane datapaths feeding m_data.
module requant_pack_stream
   import requant_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [SCALE_W-1:0]       cfg_scale,
   input  logic [SHIFT_W-1:0]       cfg_shift,
   input  logic [OUT_W-1:0]         cfg_zero,
   input  logic [CNT_W-1:0]         cfg_total_beats,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [LANES*ACC_W-1:0]   s_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [LANES*OUT_W-1:0]   m_data,
   output logic                     m_last,
   output logic                     busy,
   output logic                     done
);
   state_t           state;
   cfg_t             cfg;
   logic [CNT_W-1:0] in_cnt;
   logic             s1_valid;
   logic             s1_last;
   logic             s1_load;
   logic             s2_load;
   logic             accept;
   logic             beat_last;

   // A stage loads when it is empty or the stage after it is loading
   assign s2_load   = !m_valid || m_ready;
   assign s1_load   = !s1_valid || s2_load;
   assign s_ready   = (state == RUN) && s1_load;
   assign accept    = s_valid && s_ready;
   assign beat_last = (in_cnt == cfg.total - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cfg      <= '0;
         in_cnt   <= '0;
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         m_valid  <= 1'b0;
         m_last   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= (state == DONE);
         if (s1_load) begin
            s1_valid <= accept;
            s1_last  <= accept && beat_last;
         end
         if (s2_load) begin
            m_valid <= s1_valid;
            m_last  <= s1_last;
         end
         if (accept) in_cnt <= in_cnt + CNT_W'(1);
         case (state)
            IDLE: if (start) begin
               cfg.scale <= cfg_scale;
               cfg.shift <= cfg_shift;
               cfg.zero  <= cfg_zero;
               cfg.total <= cfg_total_beats;
               in_cnt    <= '0;
               busy      <= 1'b1;
               state     <= (cfg_total_beats == '0) ? DONE : RUN;
            end
            RUN:   if (accept && beat_last) state <= DRAIN;
            DRAIN: if (m_valid && m_ready && m_last) state <= DONE;
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
      requant_lane u_lane (
         .clk     (clk),
         .rst     (rst),
         .s1_load (accept),
         .s2_load (s2_load && s1_valid),
         .acc     (s_data[i*ACC_W +: ACC_W]),
         .scale   (cfg.scale),
         .shift   (cfg.shift),
         .zero    (cfg.zero),
         .q       (m_data[i*OUT_W +: OUT_W])
      );
   end
endmodule

// File: tb/tb_requant_pack_stream.sv
// Self-checking bench for requant_pack_stream: constant vector table, hand-written
// frame sequences and randomized backpressure frames against an arithmetic model.
module tb_requant_pack_stream;
   localparam int LANES = 8;
   localparam int ACC_W = 32;
   localparam int OUT_W = 8;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   start;
   logic [15:0]            cfg_scale;
   logic [4:0]             cfg_shift;
   logic [7:0]             cfg_zero;
   logic [31:0]            cfg_total_beats;
   logic                   s_valid;
   logic                   s_ready;
   logic [LANES*ACC_W-1:0] s_data;
   logic                   m_valid;
   logic                   m_ready;
   logic [LANES*OUT_W-1:0] m_data;
   logic                   m_last;
   logic                   busy;
   logic                   done;

   requant_pack_stream dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_zero(cfg_zero),
      .cfg_total_beats(cfg_total_beats),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int chk_cnt = 0;
   int pass_cnt = 0;
   int f_scale, f_shift, f_zero, f_total;
   int acc_idx = 0;
   int done_cnt = 0;
   int done_base = 0;
   int rdy_pct = 100;
   logic [63:0] exp_q[$];
   logic        exp_last_q[$];
   logic [63:0] rx_words[$];
   logic        rx_lasts[$];
   logic        prev_stall = 1'b0;
   logic [63:0] prev_data;
   logic        prev_last;

   typedef struct {
      int         sc;
      int         sh;
      int         zp;
      int         acc;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      chk_cnt++;
      if (got === want) pass_cnt++;
      else $display("FAIL %s: got %0h, want %0h", name, got, want);
   endtask

   // Real-valued requantisation: multiply, round half up, floor-shift, add zero, clamp
   function automatic logic [7:0] ref_byte(int acc, int sc, int sh, int zp);
      longint p;
      p = longint'(acc) * longint'(sc);
      if (sh > 0) p = p + (longint'(1) << (sh - 1));
      p = p >>> sh;
      p = p + longint'(zp);
      if (p > 127) p = 127;
      else if (p < -128) p = -128;
      return 8'(p);
   endfunction

   function automatic logic [63:0] ref_word(logic [LANES*ACC_W-1:0] d);
      logic [63:0] w;
      logic [31:0] a;
      for (int i = 0; i < LANES; i++) begin
         a = d[i*ACC_W +: ACC_W];
         w[i*OUT_W +: OUT_W] = ref_byte(int'($signed(a)), f_scale, f_shift, f_zero);
      end
      return w;
   endfunction

   function automatic logic [LANES*ACC_W-1:0] rnd_data(int mode);
      logic [LANES*ACC_W-1:0] d;
      for (int i = 0; i < LANES; i++) begin
         if (mode == 0) d[i*ACC_W +: ACC_W] = 32'(int'($urandom_range(0, 2000)) - 1000);
         else           d[i*ACC_W +: ACC_W] = $urandom;
      end
      return d;
   endfunction

   // Scoreboard: record accepted beats, compare delivered words, check stall hold
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall)
               chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
            if (s_valid && s_ready) begin
               exp_q.push_back(ref_word(s_data));
               exp_last_q.push_back(acc_idx == f_total - 1);
               acc_idx++;
            end
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_word", 1, 0);
               end else begin
                  chk("word", m_data, exp_q.pop_front());
                  chk("last", m_last, exp_last_q.pop_front());
               end
               rx_words.push_back(m_data);
               rx_lasts.push_back(m_last);
            end
            if (done) done_cnt++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
         end
      end
   end

   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         m_ready = (int'($urandom_range(99)) < rdy_pct);
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", pass_cnt, chk_cnt);
      $fatal(1);
   end

   // All tasks start and end at posedge+1
   task automatic start_frame(input int sc, input int sh, input int zp, input int tot);
      f_scale = sc; f_shift = sh; f_zero = zp; f_total = tot;
      acc_idx = 0;
      done_base = done_cnt;
      rx_words.delete();
      rx_lasts.delete();
      start = 1'b1;
      cfg_scale = 16'(sc);
      cfg_shift = 5'(sh);
      cfg_zero = 8'(zp);
      cfg_total_beats = 32'(tot);
      @(posedge clk); #1;
      start = 1'b0;
      cfg_scale = 16'($urandom);
      cfg_shift = 5'($urandom);
      cfg_zero = 8'($urandom);
      cfg_total_beats = $urandom;
   endtask

   task automatic send_beat(input logic [LANES*ACC_W-1:0] d, input int vpct);
      int guard;
      guard = 0;
      while (int'($urandom_range(99)) >= vpct && guard < 50) begin
         s_valid = 1'b0;
         @(posedge clk); #1;
         guard++;
      end
      s_valid = 1'b1;
      s_data = d;
      guard = 0;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         guard++;
         if (guard > 500) begin
            chk("send_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_data = rnd_data(1);
   endtask

   task automatic finish_frame(input int nwords, input string tag);
      int guard;
      guard = 0;
      while (done_cnt == done_base && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, "_done_seen"}, done_cnt != done_base, 1);
      repeat (3) @(negedge clk);
      chk({tag, "_done_once"}, done_cnt - done_base, 1);
      chk({tag, "_word_count"}, rx_words.size(), nwords);
      chk({tag, "_model_drained"}, exp_q.size(), 0);
      chk({tag, "_idle"}, busy, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [LANES*ACC_W-1:0] d;
      logic [31:0] a;
      logic [7:0]  e;

      tbl[0]  = '{1, 0, 0, 5, 8'h05};
      tbl[1]  = '{1, 0, 0, -3, 8'hFD};
      tbl[2]  = '{1, 0, 0, 127, 8'h7F};
      tbl[3]  = '{1, 0, 0, -128, 8'h80};
      tbl[4]  = '{256, 4, 0, 100, 8'h7F};
      tbl[5]  = '{256, 4, 0, -100, 8'h80};
      tbl[6]  = '{256, 4, -5, 0, 8'hFB};
      tbl[7]  = '{1, 2, 0, 6, 8'h02};
      tbl[8]  = '{1, 2, 0, 5, 8'h01};
      tbl[9]  = '{1, 2, 0, -6, 8'hFF};
      tbl[10] = '{1, 2, 0, -7, 8'hFE};
      tbl[11] = '{3, 1, 10, -5, 8'h03};
      tbl[12] = '{-2, 0, 0, 64, 8'h80};
      tbl[13] = '{1, 31, 0, 32'h7FFFFFFF, 8'h01};

      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
      cfg_scale = '0; cfg_shift = '0; cfg_zero = '0; cfg_total_beats = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {s_ready, m_valid, m_last, busy, done}, 5'b0);
      chk("reset_m_data", m_data, 64'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic frame: four identical beats, last only on word 4
      rdy_pct = 100;
      d = '0;
      d[0*32 +: 32] = 32'd5;
      d[1*32 +: 32] = -32'sd3;
      d[2*32 +: 32] = 32'd127;
      d[3*32 +: 32] = -32'sd128;
      d[4*32 +: 32] = 32'd0;
      d[5*32 +: 32] = 32'd1;
      d[6*32 +: 32] = -32'sd1;
      d[7*32 +: 32] = 32'd200;
      start_frame(1, 0, 0, 4);
      for (int i = 0; i < 4; i++) send_beat(d, 100);
      s_valid = 1'b1;
      @(negedge clk);
      chk("no_extra_beat", s_ready, 0);
      @(posedge clk); #1;
      s_valid = 1'b0;
      finish_frame(4, "basic");
      for (int i = 0; i < rx_words.size(); i++) begin
         chk("basic_word", rx_words[i], 64'h7FFF0100807FFD05);
         chk("basic_last", rx_lasts[i], i == 3);
      end

      // Constant vector table, one single-beat frame per entry
      foreach (tbl[k]) begin
         a = 32'(tbl[k].acc);
         e = tbl[k].exp;
         start_frame(tbl[k].sc, tbl[k].sh, tbl[k].zp, 1);
         send_beat({LANES{a}}, 100);
         finish_frame(1, "tbl");
         if (rx_words.size() > 0) begin
            chk("tbl_byte", rx_words[0], {LANES{e}});
            chk("tbl_last", rx_lasts[0], 1);
         end else begin
            chk("tbl_missing", 0, 1);
         end
      end

      // Randomized frames with sparse s_valid and 30% m_ready
      for (int f = 0; f < 3; f++) begin
         rdy_pct = 30;
         start_frame(int'($urandom_range(0, 65535)) - 32768,
                     (f == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(8, 31)),
                     int'($urandom_range(0, 255)) - 128, 16);
         for (int i = 0; i < 16; i++) send_beat(rnd_data(f == 0 ? 0 : 1), 50);
         finish_frame(16, "rand");
      end
      rdy_pct = 100;

      // Empty frame: done two cycles after start, nothing emitted
      start_frame(1, 0, 0, 0);
      @(negedge clk);
      chk("empty_first", {done, busy, m_valid, s_ready}, 4'b0100);
      @(negedge clk);
      chk("empty_done", {done, busy, m_valid, s_ready}, 4'b1000);
      @(posedge clk); #1;
      chk("empty_no_words", rx_words.size(), 0);

      // Start pulse during RUN must not disturb the frame
      start_frame(3, 1, 3, 4);
      send_beat(rnd_data(0), 100);
      start = 1'b1; cfg_scale = 16'd2; cfg_shift = 5'd0; cfg_zero = 8'd0; cfg_total_beats = 32'd1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) send_beat(rnd_data(0), 100);
      finish_frame(4, "ignore_start");

      // Reset in the middle of an 8-beat frame, then a fresh frame
      start_frame(7, 2, -1, 8);
      for (int i = 0; i < 3; i++) send_beat(rnd_data(0), 100);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_state", {m_valid, busy, s_ready, done}, 4'b0);
      rst = 1'b0;
      exp_q.delete();
      exp_last_q.delete();
      repeat (4) @(negedge clk);
      chk("midrst_no_done", done_cnt - done_base, 0);
      @(posedge clk); #1;
      rdy_pct = 60;
      start_frame(int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 4)), 9, 5);
      for (int i = 0; i < 5; i++) send_beat(rnd_data(0), 70);
      finish_frame(5, "after_rst");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
